// File: rtl/riot_timer_io.sv
// RIOT-style interval timer and 8-bit I/O port on the MPU data bus.
// Port A with direction register, prescaled countdown timer, IRQ.
module riot_timer_io #(
  parameter logic [7:0] TIMER_RESET  = 8'h00,
  parameter logic       IRQ_RESET_EN = 1'b0
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       CS,
  input  logic       R_W,
  input  logic [4:0] A,
  input  logic [7:0] WD,
  output logic [7:0] RD,
  input  logic [7:0] PA_IN,
  output logic [7:0] PA_OUT,
  output logic [7:0] PA_OE,
  output logic       IRQ_N
);

  typedef enum logic {
    NORMAL,
    FAST
  } tstate_t;

  logic [7:0] ora;
  logic [7:0] ddra;
  logic [7:0] intim;
  logic [1:0] div_sel;
  logic [9:0] pcnt;
  logic       flag;
  logic       irq_en;
  tstate_t    state;

  logic wr;
  logic rd_acc;
  logic load;
  logic intim_rd;
  logic tick;
  logic unf;

  function automatic logic [9:0] div_m1(input logic [1:0] s);
    logic [9:0] r;
    r = 10'd0;
    unique case (s)
      2'd0: r = 10'd0;
      2'd1: r = 10'd7;
      2'd2: r = 10'd63;
      2'd3: r = 10'd1023;
    endcase
    return r;
  endfunction

  assign wr       = CS & ~R_W;
  assign rd_acc   = CS & R_W;
  assign load     = wr & A[4] & A[2];
  assign intim_rd = rd_acc & A[2] & ~A[0];
  assign tick     = (pcnt == 10'd0);
  assign unf      = tick & (intim == 8'h00);

  assign PA_OUT = ora;
  assign PA_OE  = ddra;
  assign IRQ_N  = ~(flag & irq_en);

  // Port A output and direction registers.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      ora  <= 8'h00;
      ddra <= 8'h00;
    end else if (wr) begin
      if (A == 5'h00) ora  <= WD;
      if (A == 5'h01) ddra <= WD;
    end
  end

  // Timer: load, prescaled countdown, underflow into fast mode.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      intim   <= TIMER_RESET;
      div_sel <= 2'd3;
      pcnt    <= 10'd1023;
      flag    <= 1'b0;
      irq_en  <= IRQ_RESET_EN;
      state   <= NORMAL;
    end else if (load) begin
      intim   <= WD;
      div_sel <= A[1:0];
      irq_en  <= A[3];
      pcnt    <= div_m1(A[1:0]);
      flag    <= 1'b0;
      state   <= NORMAL;
    end else begin
      if (tick) intim <= intim - 8'd1;
      if (unf) begin
        flag  <= 1'b1;
        state <= FAST;
        pcnt  <= 10'd0;
      end else if (intim_rd && state == FAST) begin
        flag  <= 1'b0;
        state <= NORMAL;
        pcnt  <= div_m1(div_sel);
      end else begin
        if (intim_rd) flag <= 1'b0;
        if (state == FAST) pcnt <= 10'd0;
        else if (tick) pcnt <= div_m1(div_sel);
        else pcnt <= pcnt - 10'd1;
      end
    end
  end

  // Read mux; independent of CS.
  always_comb begin
    RD = 8'h00;
    unique case (1'b1)
      (A == 5'h00):  RD = (PA_IN & ~ddra) | (ora & ddra);
      (A == 5'h01):  RD = ddra;
      (A[2] & ~A[0]): RD = intim;
      (A[2] & A[0]): RD = {flag, 7'b0};
      default:       RD = 8'h00;
    endcase
  end

endmodule
